// File: rtl/proc_pkg.sv
// Shared definitions for the pixel processing path: pixel size, processor mode
// encoding and the FIFO occupancy-width helper.
package proc_pkg;

    localparam int COLOR_SIZE = 8;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        THRESHOLD  = 2'd1,
        BRIGHTNESS = 2'd2,
        RSVD       = 2'd3
    } proc_mode_e;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/proc_out_fifo_mem.sv
// Storage array for proc_out_fifo: one synchronous write port, one
// asynchronous read port, no reset on the contents.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_out_fifo.sv
// Circular output FIFO behind the brightness/threshold processor, with a
// registered first-word-fall-through head. PROC_OUT_FIFO_STATS_EN adds
// read and drop counters.
module proc_out_fifo
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
`ifdef PROC_OUT_FIFO_STATS_EN
    output logic [31:0]                   words_out,
    output logic [15:0]                   drops,
`endif
    input  logic                          clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic full_w;
    logic rd_fire;
    logic wr_en;
    logic drop;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign rd_fire = out_vld_q && out_rdy;
    assign wr_en   = in_vld && (!full_w || rd_fire);
    assign drop    = in_vld && full_w && !rd_fire;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // The next head is the slot being written this cycle when the FIFO is
    // empty (or holds one word that is being read); the array has not been
    // updated yet, so take the word straight from in_data.
    always_comb begin
        out_vld_d  = (count_d != '0);
        out_data_d = out_data_q;
        if (count_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = in_data;
            end else begin
                out_data_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_vld     = out_vld_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = full_w;
    assign almost_full = (count_q >= CNT_W'(AFULL_LVL));
    assign overflow    = overflow_q;

`ifdef PROC_OUT_FIFO_STATS_EN
    logic [31:0] words_out_q, words_out_d;
    logic [15:0] drops_q, drops_d;

    always_comb begin
        words_out_d = words_out_q;
        drops_d     = drops_q;
        if (rd_fire) begin
            words_out_d = words_out_q + 32'd1;
        end
        // A drop coinciding with the clear is counted, matching overflow.
        if (clr_ovf) begin
            drops_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out_q <= '0;
            drops_q     <= '0;
        end else begin
            words_out_q <= words_out_d;
            drops_q     <= drops_d;
        end
    end

    assign words_out = words_out_q;
    assign drops     = drops_q;
`endif

endmodule

// File: tb/tb_proc_out_fifo.sv
// Self-checking bench for proc_out_fifo: a vector table for the main data
// path plus hand-written reset and statistics sequences.
module tb_proc_out_fifo;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          clr_ovf;
`ifdef PROC_OUT_FIFO_STATS_EN
    logic [31:0]   words_out;
    logic [15:0]   drops;
`endif

    proc_out_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (8),
        .AFULL_LVL  (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
`ifdef PROC_OUT_FIFO_STATS_EN
        .words_out   (words_out),
        .drops       (drops),
`endif
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          rdy;
        logic          clr;
        logic          e_vld;
        logic [DW-1:0] e_data;
        int            e_cnt;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [128];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d, input logic r, input logic c,
                       input logic ev, input logic [DW-1:0] ed, input int ec, input logic eo);
        vecs[nvec].vld    = v;
        vecs[nvec].data   = d;
        vecs[nvec].rdy    = r;
        vecs[nvec].clr    = c;
        vecs[nvec].e_vld  = ev;
        vecs[nvec].e_data = ed;
        vecs[nvec].e_cnt  = ec;
        vecs[nvec].e_ovf  = eo;
        nvec++;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [DW-1:0] ed,
                             input int ec, input logic eo);
        chk({tag, ".out_vld"}, 64'(out_vld), 64'(ev));
        chk({tag, ".count"}, 64'(count), 64'(ec));
        chk({tag, ".empty"}, 64'(empty), 64'(ec == 0));
        chk({tag, ".full"}, 64'(full), 64'(ec == 8));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(ec >= 6));
        chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
        if (ev) chk({tag, ".out_data"}, 64'(out_data), 64'(ed));
    endtask

    initial begin
        // single write, then hold for 5 cycles, then drain
        add(1, 32'hA0B1C2D3, 0, 0, 1, 32'hA0B1C2D3, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 32'hA0B1C2D3, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // fill with 0..7, head stays 0
        for (int k = 1; k <= 8; k++) add(1, DW'(k - 1), 0, 0, 1, 0, k, 0);
        // drop while full, then clear
        add(1, 32'h8, 0, 0, 1, 0, 8, 1);
        add(0, 0, 0, 1, 1, 0, 8, 0);
        // full streaming across pointer wrap
        for (int i = 0; i < 20; i++) add(1, DW'(8 + i), 1, 0, 1, DW'(i + 1), 8, 0);
        // drop and clear in the same cycle: set wins
        add(1, 32'h99, 0, 1, 1, 32'd20, 8, 1);
        add(0, 0, 0, 1, 1, 32'd20, 8, 0);
        // drain 20..27
        for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, (8 - j) > 0, DW'(20 + j), 8 - j, 0);
        // count==1 with simultaneous read and write, then empty with ready high
        add(1, 32'h55, 0, 0, 1, 32'h55, 1, 0);
        add(1, 32'h66, 1, 0, 1, 32'h66, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);

        rst_n = 1'b0; in_vld = 0; in_data = '0; out_rdy = 0; clr_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0);
        chk("reset.out_data", 64'(out_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].vld, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_data,
                      vecs[i].e_cnt, vecs[i].e_ovf);
        end

        // reset in the middle of a read burst
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 0, 0);
        step(0, 0, 1, 0);
        chk_state("pre_rst", 1, 32'h22, 2, 0);
        out_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out_vld", 64'(out_vld), 64'h0);
        chk("async_rst.count", 64'(count), 64'h0);
        chk("async_rst.empty", 64'(empty), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 0);
        chk_state("post_rst_idle", 0, 0, 0, 0);
        step(1, 32'hFF00FF00, 0, 0);
        chk_state("post_rst_wr", 1, 32'hFF00FF00, 1, 0);
        step(0, 0, 1, 0);
        chk_state("post_rst_rd", 0, 0, 0, 0);

`ifdef PROC_OUT_FIFO_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stats_rst.words_out", 64'(words_out), 64'h0);
        chk("stats_rst.drops", 64'(drops), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1, DW'(k), 0, 0);
        step(1, 32'hD0, 0, 0);
        step(1, 32'hD1, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 1, 0);
        step(1, 32'hE0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 32'hE1, 0, 0);
        step(0, 0, 1, 0);
        chk("stats.words_out", 64'(words_out), 64'd10);
        chk("stats.drops", 64'(drops), 64'd2);
        step(0, 0, 0, 1);
        chk("stats_clr.drops", 64'(drops), 64'd0);
        chk("stats_clr.words_out", 64'(words_out), 64'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
